vector_mac_pipe: RTL

- Parametrised, streaming successor to the fixed 32-lane masked-sum accumulator.
- Each accepted beat sums the selected lanes of a NUM_LANES-wide vector through a fully pipelined binary adder tree.
- Tree results accumulate across a frame delimited by in_last; the frame total is published with a one-cycle valid pulse and an overflow flag.
- Sits between the per-lane datapath and the downstream result consumer. Accepts one beat per cycle with no back-pressure.

---
 rtl/vector_mac_pkg.sv | 23 ++
 rtl/adder_tree_pipe.sv | 87 ++++++++
 rtl/vector_mac_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vector_mac_pkg.sv
// Shared defaults, lane type and elaboration helpers for the vector MAC pipeline.
package vector_mac_pkg;

  localparam int unsigned DEF_NUM_LANES = 32;
  localparam int unsigned DEF_VEC_WIDTH = 10;
  localparam int unsigned DEF_ACC_WIDTH = 27;

  typedef logic [DEF_VEC_WIDTH-1:0] lane_t;

  // Ceiling log2 usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Masked, fully pipelined binary adder tree with a valid/last sideband that
// travels alongside the data; flush drops every beat currently in the tree.
module adder_tree_pipe
  import vector_mac_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned IN_WIDTH  = DEF_VEC_WIDTH,
  localparam int unsigned LEVELS    = clog2(NUM_LANES),
  localparam int unsigned OUT_WIDTH = IN_WIDTH + LEVELS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data [NUM_LANES],
  input  logic [NUM_LANES-1:0] in_sel,
  input  logic                 in_last,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 sum_valid,
  output logic                 sum_last,
  output logic                 any_valid_c
);

  logic [LEVELS-1:0] valid_d, valid_q;
  logic [LEVELS-1:0] last_d, last_q;

  // One register stage per level; each level widens by one bit so sums never overflow.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned NODES = NUM_LANES >> k;
    localparam int unsigned W     = IN_WIDTH + k;

    logic [W-1:0] node_d [NODES];
    logic [W-1:0] node_q [NODES];

    if (k == 1) begin : g_leaf
      always_comb begin
        for (int unsigned i = 0; i < NODES; i++) begin
          node_d[i] = (in_sel[2*i]   ? W'(in_data[2*i])   : '0)
                    + (in_sel[2*i+1] ? W'(in_data[2*i+1]) : '0);
        end
      end
    end else begin : g_node
      always_comb begin
        for (int unsigned i = 0; i < NODES; i++) begin
          node_d[i] = W'(g_lvl[k-1].node_q[2*i]) + W'(g_lvl[k-1].node_q[2*i+1]);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < NODES; i++) node_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < NODES; i++) node_q[i] <= node_d[i];
      end
    end
  end

  always_comb begin
    valid_d = '0;
    last_d  = '0;
    if (!flush) begin
      valid_d[0] = in_valid;
      last_d[0]  = in_valid & in_last;
      for (int unsigned i = 1; i < LEVELS; i++) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign sum         = g_lvl[LEVELS].node_q[0];
  assign sum_valid   = valid_q[LEVELS-1];
  assign sum_last    = last_q[LEVELS-1];
  assign any_valid_c = |valid_q;

endmodule

// File: rtl/vector_mac_pipe.sv
// Streaming masked vector sum: adder tree feeding a per-frame accumulator that
// publishes each frame total with a one-cycle valid pulse and an overflow flag.
module vector_mac_pipe
  import vector_mac_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned VEC_WIDTH = DEF_VEC_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [VEC_WIDTH-1:0] in_data [NUM_LANES],
  input  logic [NUM_LANES-1:0] in_sel,
  input  logic                 in_last,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int unsigned LEVELS = clog2(NUM_LANES);
  localparam int unsigned TREE_W = VEC_WIDTH + LEVELS;
  localparam int unsigned SUM_W  = ACC_WIDTH + 1;

  logic [TREE_W-1:0]    tree_sum;
  logic                 tree_valid;
  logic                 tree_last;
  logic                 tree_busy_c;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 ovf_d, ovf_q;
  logic                 open_d, open_q;
  logic [ACC_WIDTH-1:0] out_d, out_q;
  logic                 out_ovf_d, out_ovf_q;
  logic                 out_valid_d, out_valid_q;

  logic [ACC_WIDTH-1:0] base;
  logic [SUM_W-1:0]     sum_ext;
  logic                 ovf_beat;
  logic [ACC_WIDTH-1:0] result;

  adder_tree_pipe #(
    .NUM_LANES (NUM_LANES),
    .IN_WIDTH  (VEC_WIDTH)
  ) u_tree (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_last     (in_last),
    .flush       (clear),
    .sum         (tree_sum),
    .sum_valid   (tree_valid),
    .sum_last    (tree_last),
    .any_valid_c (tree_busy_c)
  );

  // A closed frame restarts from zero; the carry out of the wide sum is the overflow.
  always_comb begin
    base     = open_q ? acc_q : '0;
    sum_ext  = SUM_W'(base) + SUM_W'(tree_sum);
    ovf_beat = sum_ext[ACC_WIDTH] | (open_q & ovf_q);
    result   = sum_ext[ACC_WIDTH-1:0];
    if (SATURATE != 0 && ovf_beat) result = '1;
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    open_d      = open_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    if (clear) begin
      acc_d  = '0;
      ovf_d  = 1'b0;
      open_d = 1'b0;
    end else if (tree_valid) begin
      if (tree_last) begin
        out_d       = result;
        out_ovf_d   = ovf_beat;
        out_valid_d = 1'b1;
        acc_d       = '0;
        ovf_d       = 1'b0;
        open_d      = 1'b0;
      end else begin
        acc_d  = result;
        ovf_d  = ovf_beat;
        open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      open_q      <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      open_q      <= open_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out          = out_q;
  assign out_overflow = out_ovf_q;
  assign out_valid    = out_valid_q;
  assign busy         = tree_busy_c | open_q;

endmodule
